dda_raycaster_core: RTL and testbench
=====================================

Name: dda_raycaster_core

Overview:
Parametrised DDA ray-march engine. Accepts one precomputed ray per handshake, walks the N×N map grid by fetching cells from map BRAM, and detects wall hit, map edge or step limit. Emits line height, wall side, cell value and texture coordinate through a ready/valid output toward the column FIFO/articulator. Successor to the fixed 24×24, 8.8-only DDA FSM: generic width and map size, bounds/step-limit termination, internal fixed-latency divider, held-valid output.

Parameters:
N, 24, map side length in cells
W, 16, fixed-point word width for pos/dist/dir
FRAC_BITS, 8, fractional bits in all fixed-point inputs
SCREEN_HEIGHT, 180, maximum line height in pixels
SCREEN_WIDTH, 320, screen width; HC_W = $clog2(SCREEN_WIDTH)
MAX_STEPS, 64, step cap per ray
MAP_W, 4, map cell data width

Ports:
pixel_clk_in  in  1  clock
rst_in  in  1  reset, synchronous active-high
ray_valid_in  in  1  ray offered
ray_ready_out  out  1  high only in IDLE
hcount_ray_in  in  HC_W  ray column
step_x_in, step_y_in  in  1 each  1=+1, 0=-1
ray_dir_x_in, ray_dir_y_in  in  W each  signed fixed point
delta_dist_x_in, delta_dist_y_in  in  W each  unsigned fixed point
pos_x_in, pos_y_in  in  W each  unsigned fixed point
side_dist_x_in, side_dist_y_in  in  W each  unsigned fixed point
map_addra_out  out  $clog2(N*N)  mapX + N*mapY
map_request_out  out  1  one-cycle fetch pulse
map_data_in  in  MAP_W  cell value
map_data_valid_in  in  1  cell value valid
out_valid_out  out  1  result valid, held until accepted
out_ready_in  in  1  downstream ready
hcount_ray_out  out  HC_W  latched ray column
line_height_out  out  $clog2(SCREEN_HEIGHT+1)  wall height
wall_type_out  out  1  0=X side, 1=Y side
map_data_out  out  MAP_W  hit cell value
wall_x_out  out  FRAC_BITS  fractional hit position
hit_kind_out  out  2  00 wall, 01 map edge, 10 step limit
busy_out  out  1  high outside IDLE

Behaviour:
- Reset: all outputs 0, except ray_ready_out=1; state IDLE; step counter 0. Reset mid-ray abandons the ray; a later map_data_valid_in is ignored.
- IDLE: ray_valid_in && ray_ready_out latches all ray inputs. mapX/mapY = integer part of pos (bits W-1:FRAC_BITS). Next state is STEP.
- STEP: X step if sideX < sideY, else Y step (a tie steps Y).
  - Compute the next coordinate. If it is <0 or >=N, go to OUTPUT with hit_kind=01, map_data=0, line_height=1, and issue no request.
  - If step count == MAX_STEPS, go to OUTPUT with hit_kind=10, line_height=1.
  - Otherwise: update map coordinate, sideDist += deltaDist (wrap not possible by contract), increment count, set wall_type, drive map_addra_out, pulse map_request_out, go to WAIT_MAP.
- WAIT_MAP: map_addra_out is held stable. On map_data_valid_in (at least 1 cycle later, any delay): a zero cell returns to STEP; a nonzero cell stores the value and goes to DIV. map_data_valid_in is ignored in all other states.
- DIV: perp = side - delta on the hit axis, clamped to 0 on underflow.
  - perp==0: line_height=SCREEN_HEIGHT, skip the divider.
  - Else internal restoring divider, (SCREEN_HEIGHT<<FRAC_BITS)/perp, one quotient bit per cycle, fixed latency NUM_W = $clog2(SCREEN_HEIGHT+1)+FRAC_BITS cycles.
  - line_height = min(quotient, SCREEN_HEIGHT), never 0 (0 → 1).
- WALLX (feature): one cycle, then OUTPUT.
- OUTPUT: out_valid_out=1 with all outputs stable until the cycle out_ready_in=1. Next cycle: out_valid_out=0, state IDLE, ray_ready_out=1. ray_valid_in is ignored while busy.
- Minimum latency, accept → valid, wall in first cell: 1+1+2+NUM_W+1 cycles.

Optional Feature:
DDA_WALLX_EN
- Defined: WALLX state computes wall_x_out = fractional bits of (pos_on_other_axis + perp*ray_dir_other_axis). "Other axis" is Y for an X-side hit, X for a Y-side hit. Signed multiply is W×W; the product is truncated at FRAC_BITS.
- Undefined: the WALLX state is skipped and wall_x_out = all ones.

Test Plan:
- Wall-hit case (N=24, W=16, FRAC=8):
  - Stimulus: pos=(0x0280,0x0280), step +1/+1, side=(0x0080,0x0800), delta=(0x0100,0x1000), dirY=0x0040, wall only at (5,2).
  - Response: addresses 51, 52, 53; hit_kind 00; wall_type 0; line_height 72.
  - With DDA_WALLX_EN: wall_x_out=0x20.
- Zero distance: pos=(0x0300,0x0300), side=(0x0000,0x0800), deltaX=0x0100, wall at (4,3) → address 76, line_height 180.
- Map edge: mapX=23, stepX=+1, sideX<sideY, empty map → no request issued, hit_kind 01, map_data_out 0, line_height 1.
- Step limit: MAX_STEPS=4, empty interior → exactly 4 requests, then hit_kind 10.
- Backpressure: out_ready_in low for 10 cycles → outputs stable, out_valid_out held, extra ray_valid_in ignored; accept on the 11th cycle → ray_ready_out=1 next cycle.
- Reset in WAIT_MAP: rst_in for 1 cycle → reset values; a late map_data_valid_in is ignored; the following ray matches the wall-hit case.

Source files
------------

// File: rtl/dda_raycaster_core_if.sv
// rtl/dda_raycaster_core_if.sv - ray input, map fetch and result handshake bundle for dda_raycaster_core
interface dda_raycaster_core_if #(
  parameter int N             = 24,
  parameter int W             = 16,
  parameter int FRAC_BITS     = 8,
  parameter int SCREEN_HEIGHT = 180,
  parameter int SCREEN_WIDTH  = 320,
  parameter int MAP_W         = 4
);
  localparam int HC_W = $clog2(SCREEN_WIDTH);
  localparam int AW   = $clog2(N * N);
  localparam int LH_W = $clog2(SCREEN_HEIGHT + 1);

  logic                 ray_valid_in;
  logic                 ray_ready_out;
  logic [HC_W-1:0]      hcount_ray_in;
  logic                 step_x_in;
  logic                 step_y_in;
  logic signed [W-1:0]  ray_dir_x_in;
  logic signed [W-1:0]  ray_dir_y_in;
  logic [W-1:0]         delta_dist_x_in;
  logic [W-1:0]         delta_dist_y_in;
  logic [W-1:0]         pos_x_in;
  logic [W-1:0]         pos_y_in;
  logic [W-1:0]         side_dist_x_in;
  logic [W-1:0]         side_dist_y_in;
  logic [AW-1:0]        map_addra_out;
  logic                 map_request_out;
  logic [MAP_W-1:0]     map_data_in;
  logic                 map_data_valid_in;
  logic                 out_valid_out;
  logic                 out_ready_in;
  logic [HC_W-1:0]      hcount_ray_out;
  logic [LH_W-1:0]      line_height_out;
  logic                 wall_type_out;
  logic [MAP_W-1:0]     map_data_out;
  logic [FRAC_BITS-1:0] wall_x_out;
  logic [1:0]           hit_kind_out;
  logic                 busy_out;

  modport slave (
    input  ray_valid_in, hcount_ray_in, step_x_in, step_y_in, ray_dir_x_in, ray_dir_y_in,
           delta_dist_x_in, delta_dist_y_in, pos_x_in, pos_y_in, side_dist_x_in, side_dist_y_in,
           map_data_in, map_data_valid_in, out_ready_in,
    output ray_ready_out, map_addra_out, map_request_out, out_valid_out, hcount_ray_out,
           line_height_out, wall_type_out, map_data_out, wall_x_out, hit_kind_out, busy_out
  );

  modport master (
    output ray_valid_in, hcount_ray_in, step_x_in, step_y_in, ray_dir_x_in, ray_dir_y_in,
           delta_dist_x_in, delta_dist_y_in, pos_x_in, pos_y_in, side_dist_x_in, side_dist_y_in,
           map_data_in, map_data_valid_in, out_ready_in,
    input  ray_ready_out, map_addra_out, map_request_out, out_valid_out, hcount_ray_out,
           line_height_out, wall_type_out, map_data_out, wall_x_out, hit_kind_out, busy_out
  );
endinterface

// File: rtl/dda_raycaster_core.sv
// rtl/dda_raycaster_core.sv - DDA ray-march engine: grid walk, map fetch, perp-distance divide, held-valid result
// Optional DDA_WALLX_EN adds the WALLX state computing the fractional wall hit position.
module dda_raycaster_core #(
  parameter int N             = 24,
  parameter int W             = 16,
  parameter int FRAC_BITS     = 8,
  parameter int SCREEN_HEIGHT = 180,
  parameter int SCREEN_WIDTH  = 320,
  parameter int MAX_STEPS     = 64,
  parameter int MAP_W         = 4
) (
  input logic pixel_clk_in,
  input logic rst_in,
  dda_raycaster_core_if.slave bus
);
  localparam int HC_W  = $clog2(SCREEN_WIDTH);
  localparam int AW    = $clog2(N * N);
  localparam int CW    = $clog2(N);
  localparam int LH_W  = $clog2(SCREEN_HEIGHT + 1);
  localparam int NUM_W = LH_W + FRAC_BITS;
  localparam int SC_W  = $clog2(MAX_STEPS + 1);
  localparam int DC_W  = $clog2(NUM_W + 1);
  localparam logic [NUM_W-1:0] DIVIDEND = NUM_W'(SCREEN_HEIGHT) << FRAC_BITS;
  localparam logic [LH_W-1:0]  LH_MAX   = LH_W'(SCREEN_HEIGHT);
  localparam logic [LH_W-1:0]  LH_MIN   = LH_W'(1);
`ifdef DDA_WALLX_EN
  localparam logic [FRAC_BITS-1:0] WX_NONE = '0;
`else
  localparam logic [FRAC_BITS-1:0] WX_NONE = '1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_WAIT_MAP, S_DIV, S_WALLX, S_OUTPUT} state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d, busy_q, busy_d, req_q, req_d, out_valid_q, out_valid_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [HC_W-1:0]      hc_q, hc_d;
  logic [LH_W-1:0]      lh_q, lh_d;
  logic                 wall_type_q, wall_type_d;
  logic [MAP_W-1:0]     map_data_q, map_data_d;
  logic [FRAC_BITS-1:0] wall_x_q, wall_x_d;
  logic [1:0]           hit_kind_q, hit_kind_d;
  logic                 step_x_q, step_x_d, step_y_q, step_y_d;
  logic [W-1:0]         side_x_q, side_x_d, side_y_q, side_y_d;
  logic [W-1:0]         delta_x_q, delta_x_d, delta_y_q, delta_y_d;
  logic [CW-1:0]        map_x_q, map_x_d, map_y_q, map_y_d;
  logic [SC_W-1:0]      step_cnt_q, step_cnt_d;
  logic [W-1:0]         perp_q, perp_d, rem_q, rem_d;
  logic [NUM_W-1:0]     dvd_q, dvd_d;
  logic [DC_W-1:0]      div_cnt_q, div_cnt_d;
`ifdef DDA_WALLX_EN
  logic [FRAC_BITS-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [W-1:0]  dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic signed [W-1:0]  dir_sel;
  logic signed [2*W:0]  wx_prod;
  logic [FRAC_BITS-1:0] wx_val;
`endif

  logic             x_step, at_edge;
  logic [CW-1:0]    nx, ny;
  logic [W-1:0]     perp_hit;
  logic [W:0]       rem_sh, rem_next;
  logic             fits;
  logic [NUM_W-1:0] quot_final;

  function automatic logic [LH_W-1:0] clamp_lh(input logic [NUM_W-1:0] q);
    if (q > NUM_W'(SCREEN_HEIGHT)) return LH_MAX;
    else if (q == '0)              return LH_MIN;
    else                           return q[LH_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;     ready_d = ready_q;       busy_d = busy_q;
    req_d = 1'b0;          out_valid_d = out_valid_q; addr_d = addr_q;
    hc_d = hc_q;           lh_d = lh_q;             wall_type_d = wall_type_q;
    map_data_d = map_data_q; wall_x_d = wall_x_q;   hit_kind_d = hit_kind_q;
    step_x_d = step_x_q;   step_y_d = step_y_q;
    side_x_d = side_x_q;   side_y_d = side_y_q;
    delta_x_d = delta_x_q; delta_y_d = delta_y_q;
    map_x_d = map_x_q;     map_y_d = map_y_q;       step_cnt_d = step_cnt_q;
    perp_d = perp_q;       rem_d = rem_q;           dvd_d = dvd_q;  div_cnt_d = div_cnt_q;
`ifdef DDA_WALLX_EN
    pos_x_d = pos_x_q; pos_y_d = pos_y_q; dir_x_d = dir_x_q; dir_y_d = dir_y_q;
    dir_sel = wall_type_q ? dir_x_q : dir_y_q;
    wx_prod = $signed({1'b0, perp_q}) * dir_sel;
    wx_val  = (wall_type_q ? pos_x_q : pos_y_q) + wx_prod[2*FRAC_BITS-1:FRAC_BITS];
`endif

    // Tie between side distances steps Y.
    x_step  = side_x_q < side_y_q;
    at_edge = x_step ? (step_x_q ? (map_x_q == CW'(N - 1)) : (map_x_q == '0))
                     : (step_y_q ? (map_y_q == CW'(N - 1)) : (map_y_q == '0));
    nx = map_x_q;
    ny = map_y_q;
    if (x_step) nx = step_x_q ? map_x_q + CW'(1) : map_x_q - CW'(1);
    else        ny = step_y_q ? map_y_q + CW'(1) : map_y_q - CW'(1);

    if (wall_type_q) perp_hit = (side_y_q >= delta_y_q) ? side_y_q - delta_y_q : '0;
    else             perp_hit = (side_x_q >= delta_x_q) ? side_x_q - delta_x_q : '0;

    // Restoring divider; quotient bits shift into the low end of the dividend register.
    rem_sh     = {rem_q, dvd_q[NUM_W-1]};
    fits       = rem_sh >= {1'b0, perp_q};
    rem_next   = fits ? rem_sh - {1'b0, perp_q} : rem_sh;
    quot_final = {dvd_q[NUM_W-2:0], fits};

    case (state_q)
      S_IDLE: begin
        if (bus.ray_valid_in) begin
          hc_d = bus.hcount_ray_in;
          step_x_d = bus.step_x_in;          step_y_d = bus.step_y_in;
          side_x_d = bus.side_dist_x_in;     side_y_d = bus.side_dist_y_in;
          delta_x_d = bus.delta_dist_x_in;   delta_y_d = bus.delta_dist_y_in;
          map_x_d = bus.pos_x_in[FRAC_BITS +: CW];
          map_y_d = bus.pos_y_in[FRAC_BITS +: CW];
`ifdef DDA_WALLX_EN
          pos_x_d = bus.pos_x_in[FRAC_BITS-1:0]; pos_y_d = bus.pos_y_in[FRAC_BITS-1:0];
          dir_x_d = bus.ray_dir_x_in;            dir_y_d = bus.ray_dir_y_in;
`endif
          step_cnt_d = '0;
          ready_d = 1'b0;
          busy_d = 1'b1;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (at_edge || step_cnt_q == SC_W'(MAX_STEPS)) begin
          hit_kind_d = at_edge ? 2'b01 : 2'b10;
          map_data_d = '0;
          lh_d = LH_MIN;
          wall_type_d = ~x_step;
          wall_x_d = WX_NONE;
          out_valid_d = 1'b1;
          state_d = S_OUTPUT;
        end else begin
          if (x_step) side_x_d = side_x_q + delta_x_q;
          else        side_y_d = side_y_q + delta_y_q;
          map_x_d = nx;
          map_y_d = ny;
          wall_type_d = ~x_step;
          addr_d = AW'(ny) * AW'(N) + AW'(nx);
          step_cnt_d = step_cnt_q + SC_W'(1);
          req_d = 1'b1;
          state_d = S_WAIT_MAP;
        end
      end
      S_WAIT_MAP: begin
        if (bus.map_data_valid_in) begin
          if (bus.map_data_in == '0) begin
            state_d = S_STEP;
          end else begin
            map_data_d = bus.map_data_in;
            hit_kind_d = 2'b00;
            perp_d = perp_hit;
            rem_d = '0;
            dvd_d = DIVIDEND;
            div_cnt_d = '0;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        if (perp_q == '0 || div_cnt_q == DC_W'(NUM_W - 1)) begin
          lh_d = (perp_q == '0) ? LH_MAX : clamp_lh(quot_final);
`ifdef DDA_WALLX_EN
          state_d = S_WALLX;
`else
          wall_x_d = WX_NONE;
          out_valid_d = 1'b1;
          state_d = S_OUTPUT;
`endif
        end else begin
          rem_d = rem_next[W-1:0];
          dvd_d = quot_final;
          div_cnt_d = div_cnt_q + DC_W'(1);
        end
      end
      S_WALLX: begin
`ifdef DDA_WALLX_EN
        wall_x_d = wx_val;
`else
        wall_x_d = WX_NONE;
`endif
        out_valid_d = 1'b1;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (bus.out_ready_in) begin
          out_valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;   ready_q <= 1'b1;   busy_q <= 1'b0;  req_q <= 1'b0;
      out_valid_q <= 1'b0; addr_q <= '0;      hc_q <= '0;      lh_q <= '0;
      wall_type_q <= 1'b0; map_data_q <= '0;  wall_x_q <= '0;  hit_kind_q <= '0;
      step_x_q <= 1'b0;    step_y_q <= 1'b0;  side_x_q <= '0;  side_y_q <= '0;
      delta_x_q <= '0;     delta_y_q <= '0;   map_x_q <= '0;   map_y_q <= '0;
      step_cnt_q <= '0;    perp_q <= '0;      rem_q <= '0;     dvd_q <= '0;
      div_cnt_q <= '0;
`ifdef DDA_WALLX_EN
      pos_x_q <= '0; pos_y_q <= '0; dir_x_q <= '0; dir_y_q <= '0;
`endif
    end else begin
      state_q <= state_d;   ready_q <= ready_d;   busy_q <= busy_d;   req_q <= req_d;
      out_valid_q <= out_valid_d; addr_q <= addr_d; hc_q <= hc_d;   lh_q <= lh_d;
      wall_type_q <= wall_type_d; map_data_q <= map_data_d; wall_x_q <= wall_x_d;
      hit_kind_q <= hit_kind_d;
      step_x_q <= step_x_d; step_y_q <= step_y_d; side_x_q <= side_x_d; side_y_q <= side_y_d;
      delta_x_q <= delta_x_d; delta_y_q <= delta_y_d; map_x_q <= map_x_d; map_y_q <= map_y_d;
      step_cnt_q <= step_cnt_d; perp_q <= perp_d; rem_q <= rem_d; dvd_q <= dvd_d;
      div_cnt_q <= div_cnt_d;
`ifdef DDA_WALLX_EN
      pos_x_q <= pos_x_d; pos_y_q <= pos_y_d; dir_x_q <= dir_x_d; dir_y_q <= dir_y_d;
`endif
    end
  end

  assign bus.ray_ready_out   = ready_q;
  assign bus.busy_out        = busy_q;
  assign bus.map_request_out = req_q;
  assign bus.map_addra_out   = addr_q;
  assign bus.out_valid_out   = out_valid_q;
  assign bus.hcount_ray_out  = hc_q;
  assign bus.line_height_out = lh_q;
  assign bus.wall_type_out   = wall_type_q;
  assign bus.map_data_out    = map_data_q;
  assign bus.wall_x_out      = wall_x_q;
  assign bus.hit_kind_out    = hit_kind_q;

  // Integer bits above the map range and feature-only inputs are intentionally dropped.
  logic unused_bits;
`ifdef DDA_WALLX_EN
  assign unused_bits = ^{bus.pos_x_in, bus.pos_y_in, wx_prod};
`else
  assign unused_bits = ^{bus.pos_x_in, bus.pos_y_in, bus.ray_dir_x_in, bus.ray_dir_y_in};
`endif
endmodule

// File: tb/tb_dda_raycaster_core.sv
// tb/tb_dda_raycaster_core.sv - directed self-checking bench for dda_raycaster_core
module tb_dda_raycaster_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dda_raycaster_core_if bus ();
  dda_raycaster_core #(.MAX_STEPS(4)) dut (.pixel_clk_in(clk), .rst_in(rst), .bus(bus));

  int total;
  int passed;
  logic [3:0] map_mem [0:575];
  logic       resp_en, pending, resp_valid, late_valid;
  logic [3:0] resp_data, late_data;
  logic [9:0] pend_addr;
  logic [9:0] req_log [$];
  logic [7:0] exp_wx;

  assign bus.map_data_valid_in = resp_valid | late_valid;
  assign bus.map_data_in       = late_valid ? late_data : resp_data;

  // Map BRAM model: answers a request one cycle after seeing it.
  always @(negedge clk) begin
    resp_valid = 1'b0;
    if (pending && resp_en) begin
      resp_valid = 1'b1;
      resp_data  = map_mem[pend_addr];
    end
    pending = 1'b0;
    if (bus.map_request_out === 1'b1) begin
      req_log.push_back(bus.map_addra_out);
      pending   = 1'b1;
      pend_addr = bus.map_addra_out;
    end
  end

  task automatic clear_map();
    for (int i = 0; i < 576; i++) map_mem[i] = 4'd0;
  endtask

  task automatic send_ray(input logic [15:0] px, input logic [15:0] py, input logic [15:0] sx,
                          input logic [15:0] sy, input logic [15:0] dx, input logic [15:0] dy,
                          input logic [15:0] diry, input logic stx, input logic sty,
                          input logic [8:0] hc);
    int n = 0;
    @(negedge clk);
    while (bus.ray_ready_out !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total++; $display("FAIL ray_ready_timeout got %b want 1", bus.ray_ready_out); end
    bus.pos_x_in = px;            bus.pos_y_in = py;
    bus.side_dist_x_in = sx;      bus.side_dist_y_in = sy;
    bus.delta_dist_x_in = dx;     bus.delta_dist_y_in = dy;
    bus.ray_dir_x_in = 16'sd0;    bus.ray_dir_y_in = diry;
    bus.step_x_in = stx;          bus.step_y_in = sty;
    bus.hcount_ray_in = hc;
    bus.ray_valid_in = 1'b1;
    @(negedge clk);
    bus.ray_valid_in = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (bus.out_valid_out !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin total++; $display("FAIL out_valid_timeout got %b want 1", bus.out_valid_out); end
  endtask

  task automatic accept_out();
    bus.out_ready_in = 1'b1;
    @(negedge clk);
    bus.out_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.ray_ready_out !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.ray_ready_out); else passed++;
    total++; if (bus.busy_out !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy_out); else passed++;
    total++; if (bus.out_valid_out !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.out_valid_out); else passed++;
    total++; if (bus.map_request_out !== 1'b0) $display("FAIL rst_req got %b want 0", bus.map_request_out); else passed++;
    total++; if (bus.map_addra_out !== 10'd0) $display("FAIL rst_addr got %0d want 0", bus.map_addra_out); else passed++;
    total++; if (bus.line_height_out !== 8'd0) $display("FAIL rst_lh got %0d want 0", bus.line_height_out); else passed++;
    total++; if (bus.hit_kind_out !== 2'b00) $display("FAIL rst_kind got %b want 00", bus.hit_kind_out); else passed++;
    total++; if (bus.wall_x_out !== 8'h00) $display("FAIL rst_wallx got %h want 00", bus.wall_x_out); else passed++;
  endtask

  // pos (2.5,2.5) walking +X; wall at (5,2) reached after three fetches, perp 2.5 -> 46080/640 = 72.
  task automatic run_wall_case(input string tag);
    logic [9:0] exp_a [3] = '{10'd51, 10'd52, 10'd53};
    clear_map();
    map_mem[53] = 4'd7;
    req_log.delete();
    send_ray(16'h0280, 16'h0280, 16'h0080, 16'h0800, 16'h0100, 16'h1000, 16'h0040, 1'b1, 1'b1, 9'd100);
    wait_out();
    total++; if (req_log.size() !== 3) $display("FAIL %s_nreq got %0d want 3", tag, req_log.size()); else passed++;
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_a[i]) $display("FAIL %s_addr%0d got %0d want %0d", tag, i, req_log[i], exp_a[i]); else passed++;
    end
    total++; if (bus.hit_kind_out !== 2'b00) $display("FAIL %s_kind got %b want 00", tag, bus.hit_kind_out); else passed++;
    total++; if (bus.wall_type_out !== 1'b0) $display("FAIL %s_side got %b want 0", tag, bus.wall_type_out); else passed++;
    total++; if (bus.line_height_out !== 8'd72) $display("FAIL %s_lh got %0d want 72", tag, bus.line_height_out); else passed++;
    total++; if (bus.map_data_out !== 4'd7) $display("FAIL %s_cell got %0d want 7", tag, bus.map_data_out); else passed++;
    total++; if (bus.hcount_ray_out !== 9'd100) $display("FAIL %s_hc got %0d want 100", tag, bus.hcount_ray_out); else passed++;
`ifdef DDA_WALLX_EN
    exp_wx = 8'h20;
`else
    exp_wx = 8'hFF;
`endif
    total++; if (bus.wall_x_out !== exp_wx) $display("FAIL %s_wallx got %h want %h", tag, bus.wall_x_out, exp_wx); else passed++;
  endtask

  task automatic test_wall_hit();
    run_wall_case("wall");
    accept_out();
    total++; if (bus.ray_ready_out !== 1'b1) $display("FAIL wall_ready_after got %b want 1", bus.ray_ready_out); else passed++;
    total++; if (bus.out_valid_out !== 1'b0) $display("FAIL wall_valid_after got %b want 0", bus.out_valid_out); else passed++;
  endtask

  task automatic test_zero_dist();
    clear_map();
    map_mem[76] = 4'd5;
    req_log.delete();
    send_ray(16'h0300, 16'h0300, 16'h0000, 16'h0800, 16'h0100, 16'h1000, 16'h0040, 1'b1, 1'b1, 9'd3);
    wait_out();
    total++; if (req_log.size() !== 1 || req_log[0] !== 10'd76) $display("FAIL zero_addr got n=%0d a=%0d want n=1 a=76", req_log.size(), (req_log.size() > 0) ? req_log[0] : 10'd0); else passed++;
    total++; if (bus.line_height_out !== 8'd180) $display("FAIL zero_lh got %0d want 180", bus.line_height_out); else passed++;
    total++; if (bus.map_data_out !== 4'd5) $display("FAIL zero_cell got %0d want 5", bus.map_data_out); else passed++;
    total++; if (bus.hit_kind_out !== 2'b00) $display("FAIL zero_kind got %b want 00", bus.hit_kind_out); else passed++;
    accept_out();
  endtask

  task automatic test_map_edge();
    clear_map();
    req_log.delete();
    send_ray(16'h1780, 16'h0280, 16'h0080, 16'h0800, 16'h0100, 16'h1000, 16'h0000, 1'b1, 1'b1, 9'd319);
    wait_out();
    total++; if (req_log.size() !== 0) $display("FAIL edge_hi_nreq got %0d want 0", req_log.size()); else passed++;
    total++; if (bus.hit_kind_out !== 2'b01) $display("FAIL edge_hi_kind got %b want 01", bus.hit_kind_out); else passed++;
    total++; if (bus.map_data_out !== 4'd0) $display("FAIL edge_hi_cell got %0d want 0", bus.map_data_out); else passed++;
    total++; if (bus.line_height_out !== 8'd1) $display("FAIL edge_hi_lh got %0d want 1", bus.line_height_out); else passed++;
    accept_out();
    req_log.delete();
    send_ray(16'h0080, 16'h0580, 16'h0080, 16'h0800, 16'h0100, 16'h1000, 16'h0000, 1'b0, 1'b1, 9'd0);
    wait_out();
    total++; if (req_log.size() !== 0) $display("FAIL edge_lo_nreq got %0d want 0", req_log.size()); else passed++;
    total++; if (bus.hit_kind_out !== 2'b01) $display("FAIL edge_lo_kind got %b want 01", bus.hit_kind_out); else passed++;
    total++; if (bus.line_height_out !== 8'd1) $display("FAIL edge_lo_lh got %0d want 1", bus.line_height_out); else passed++;
    accept_out();
  endtask

  task automatic test_step_limit();
    logic [9:0] exp_a [4] = '{10'd51, 10'd52, 10'd53, 10'd54};
    clear_map();
    req_log.delete();
    send_ray(16'h0280, 16'h0280, 16'h0080, 16'h8000, 16'h0100, 16'h1000, 16'h0000, 1'b1, 1'b1, 9'd42);
    wait_out();
    total++; if (req_log.size() !== 4) $display("FAIL limit_nreq got %0d want 4", req_log.size()); else passed++;
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_a[i]) $display("FAIL limit_addr%0d got %0d want %0d", i, req_log[i], exp_a[i]); else passed++;
    end
    total++; if (bus.hit_kind_out !== 2'b10) $display("FAIL limit_kind got %b want 10", bus.hit_kind_out); else passed++;
    total++; if (bus.line_height_out !== 8'd1) $display("FAIL limit_lh got %0d want 1", bus.line_height_out); else passed++;
    accept_out();
  endtask

  task automatic test_backpressure();
    run_wall_case("bp");
    bus.pos_x_in = 16'h0A80; bus.hcount_ray_in = 9'd7; bus.ray_valid_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (bus.out_valid_out !== 1'b1) $display("FAIL bp_valid%0d got %b want 1", c, bus.out_valid_out); else passed++;
      total++; if (bus.line_height_out !== 8'd72) $display("FAIL bp_lh%0d got %0d want 72", c, bus.line_height_out); else passed++;
      total++; if (bus.hcount_ray_out !== 9'd100) $display("FAIL bp_hc%0d got %0d want 100", c, bus.hcount_ray_out); else passed++;
      total++; if (bus.ray_ready_out !== 1'b0) $display("FAIL bp_ready%0d got %b want 0", c, bus.ray_ready_out); else passed++;
    end
    bus.ray_valid_in = 1'b0;
    accept_out();
    total++; if (bus.ray_ready_out !== 1'b1) $display("FAIL bp_ready_after got %b want 1", bus.ray_ready_out); else passed++;
    total++; if (bus.out_valid_out !== 1'b0) $display("FAIL bp_valid_after got %b want 0", bus.out_valid_out); else passed++;
    @(negedge clk);
    total++; if (bus.busy_out !== 1'b0) $display("FAIL bp_idle got %b want 0", bus.busy_out); else passed++;
    total++; if (req_log.size() !== 3) $display("FAIL bp_nreq got %0d want 3", req_log.size()); else passed++;
  endtask

  task automatic test_reset_wait_map();
    int n = 0;
    clear_map();
    map_mem[53] = 4'd7;
    resp_en = 1'b0;
    req_log.delete();
    send_ray(16'h0280, 16'h0280, 16'h0080, 16'h0800, 16'h0100, 16'h1000, 16'h0040, 1'b1, 1'b1, 9'd55);
    while (req_log.size() == 0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin total++; $display("FAIL rwm_req_timeout got 0 want 1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.ray_ready_out !== 1'b1) $display("FAIL rwm_ready got %b want 1", bus.ray_ready_out); else passed++;
    total++; if (bus.busy_out !== 1'b0) $display("FAIL rwm_busy got %b want 0", bus.busy_out); else passed++;
    total++; if (bus.map_addra_out !== 10'd0) $display("FAIL rwm_addr got %0d want 0", bus.map_addra_out); else passed++;
    late_data = 4'd9; late_valid = 1'b1;
    @(negedge clk);
    late_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid_out !== 1'b0) $display("FAIL rwm_late_valid got %b want 0", bus.out_valid_out); else passed++;
    total++; if (bus.busy_out !== 1'b0) $display("FAIL rwm_late_busy got %b want 0", bus.busy_out); else passed++;
    resp_en = 1'b1;
    run_wall_case("rwm");
    accept_out();
  endtask

  initial begin
    total = 0; passed = 0;
    resp_en = 1'b1; pending = 1'b0; resp_valid = 1'b0; resp_data = 4'd0;
    late_valid = 1'b0; late_data = 4'd0; pend_addr = 10'd0;
    bus.ray_valid_in = 1'b0; bus.out_ready_in = 1'b0; bus.hcount_ray_in = '0;
    bus.step_x_in = 1'b0; bus.step_y_in = 1'b0; bus.ray_dir_x_in = '0; bus.ray_dir_y_in = '0;
    bus.delta_dist_x_in = '0; bus.delta_dist_y_in = '0; bus.pos_x_in = '0; bus.pos_y_in = '0;
    bus.side_dist_x_in = '0; bus.side_dist_y_in = '0;
    clear_map();
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_wall_hit();
    test_zero_dist();
    test_map_edge();
    test_step_limit();
    test_backpressure();
    test_reset_wait_map();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
